// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with an in-order {inst, pc, npc} queue feeding decode.
// Optional macro FETCH_JAL_PREDICT_EN: predict JAL targets as the next fetch PC.
`default_nettype none

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    input  logic        jump_valid,
    input  logic [31:0] jump_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_npc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic           mem_req_q, mem_req_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [31:0]    inst_q [DEPTH];
    logic [31:0]    inst_d [DEPTH];
    logic [31:0]    pc_q   [DEPTH];
    logic [31:0]    pc_d   [DEPTH];
    logic [31:0]    npc_q  [DEPTH];
    logic [31:0]    npc_d  [DEPTH];

    logic           w_out_valid;
    logic           w_pop;
    logic           w_push;
    logic [31:0]    w_npc;
    logic [CW-1:0]  w_count_after_push;

    assign w_out_valid        = (count_q != '0) && !jump_valid;
    assign w_pop              = rdy_in && w_out_valid && out_ready;
    assign w_count_after_push = count_q + CW'(1) - CW'(w_pop);

    always_comb begin
        w_npc = fetch_pc_q + 32'd4;
`ifdef FETCH_JAL_PREDICT_EN
        if (mem_data[6:0] == 7'b1101111) begin
            w_npc = fetch_pc_q + {{11{mem_data[31]}}, mem_data[31], mem_data[19:12],
                                  mem_data[20], mem_data[30:21], 1'b0};
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        npc_d      = npc_q;
        w_push     = 1'b0;

        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (!jump_valid && (count_q < c_depth)) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_pc_q;
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack && !jump_valid) begin
                        w_push     = 1'b1;
                        fetch_pc_d = w_npc;
                        if (w_count_after_push < c_depth) begin
                            mem_addr_d = w_npc;
                        end else begin
                            mem_req_d = 1'b0;
                            state_d   = ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (w_push) begin
                inst_d[tail_q] = mem_data;
                pc_d[tail_q]   = fetch_pc_q;
                npc_d[tail_q]  = w_npc;
                tail_d         = tail_q + PW'(1);
            end
            if (w_pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(w_push) - CW'(w_pop);

            // A redirect overrides any push/pop and abandons an in-flight request.
            if (jump_valid) begin
                fetch_pc_d = jump_pc;
                count_d    = '0;
                head_d     = '0;
                tail_d     = '0;
                if (state_q == ST_WAIT) begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            inst_q     <= '{default: '0};
            pc_q       <= '{default: '0};
            npc_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = w_out_valid;
    assign out_inst  = inst_q[head_q];
    assign out_pc    = pc_q[head_q];
    assign out_npc   = npc_q[head_q];

endmodule

`default_nettype wire
